puf_ecc_engine: RTL

- Parametrised successor to the PUF SECDED provisioning/correction block; sits between the PUF and the PCM key/ID logic.
- Stores Hamming SECDED helper parity per IP-ID slot at enrollment and later corrects noisy PUF signatures.
- Processes one DATA_W chunk per cycle, so one datapath serves any SIG_W.
- Adds valid/ready handshakes, per-slot enrolled/lock tracking, a clear command, error statistics and uncorrectable-error reporting.

---
 rtl/puf_ecc_engine.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/puf_ecc_engine.sv
`timescale 1ns/1ps
// puf_ecc_engine: SECDED helper-parity enrollment and correction for PUF
// signatures. One DATA_W chunk is encoded or decoded per cycle against a
// per-slot parity store, so a single datapath serves any signature width.
module puf_ecc_engine #(
   parameter int SIG_W  = 256,
   parameter int DATA_W = 16,
   parameter int IPID_N = 16,
   localparam int NCHUNK = SIG_W / DATA_W,
   localparam int IDW    = (IPID_N > 1) ? $clog2(IPID_N) : 1,
   localparam int CW     = $clog2(NCHUNK + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [IDW-1:0]    cmd_ipid,
   input  logic [SIG_W-1:0]  cmd_sig,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [2:0]        rsp_status,
   output logic [SIG_W-1:0]  rsp_sig,
   output logic [CW-1:0]     rsp_corr_cnt,
   output logic [NCHUNK-1:0] rsp_uncorr_mask,
   output logic [IPID_N-1:0] enrolled
);

   // Smallest h with 2^h >= dw + h + 1.
   function automatic int calc_h(input int dw);
      int h;
      h = 0;
      for (int i = 1; i < 31; i++)
         if (h == 0 && (1 << i) >= dw + i + 1) h = i;
      return h;
   endfunction

   localparam int H     = calc_h(DATA_W);
   localparam int PAR_W = H + 1;
   localparam int CWL   = DATA_W + H;
   localparam int KW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_ENROLL  = 2'b01;
   localparam logic [1:0] OP_CORRECT = 2'b10;
   localparam logic [1:0] OP_CLEAR   = 2'b11;

   localparam logic [2:0] ST_OK           = 3'd0;
   localparam logic [2:0] ST_CORRECTED    = 3'd1;
   localparam logic [2:0] ST_UNCORR       = 3'd2;
   localparam logic [2:0] ST_NOT_ENROLLED = 3'd3;
   localparam logic [2:0] ST_LOCKED       = 3'd4;
   localparam logic [2:0] ST_BAD_IPID     = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_ENROLL, S_CORRECT, S_RESP} state_t;

   // Check bit i covers data at codeword positions with bit i set; data
   // occupies the non-power-of-two positions in ascending order. The top
   // bit is the overall parity over data and check bits.
   function automatic logic [PAR_W-1:0] encode(input logic [DATA_W-1:0] data);
      logic [PAR_W-1:0] par;
      int d;
      par = '0;
      d   = 0;
      for (int pos = 1; pos <= CWL; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            for (int i = 0; i < H; i++)
               if (pos[i]) par[i] = par[i] ^ data[d];
            d++;
         end
      end
      par[H] = (^data) ^ (^par[H-1:0]);
      return par;
   endfunction

   // Flip the data bit whose codeword position equals the syndrome; a
   // syndrome pointing at a check position leaves the data unchanged.
   function automatic logic [DATA_W-1:0] flip_at(input logic [DATA_W-1:0] data,
                                                 input logic [H-1:0]      syn);
      logic [DATA_W-1:0] res;
      int d;
      res = data;
      d   = 0;
      for (int pos = 1; pos <= CWL; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (pos == int'(syn)) res[d] = ~res[d];
            d++;
         end
      end
      return res;
   endfunction

   state_t                         state;
   logic [NCHUNK-1:0][DATA_W-1:0]  sig_q;
   logic [NCHUNK-1:0][DATA_W-1:0]  out_q;
   logic [IDW-1:0]                 ipid_q;
   logic [KW-1:0]                  k;

   // NOTE: the parity store is deliberately left out of reset; the enrolled
   // flags alone decide whether a slot's contents may be trusted.
   logic [PAR_W-1:0] par_mem [IPID_N][NCHUNK];

   logic [DATA_W-1:0] chunk, fixed;
   logic [PAR_W-1:0]  calc_par, stored_par;
   logic [H-1:0]      syn;
   logic              par_err, last_chunk;
   logic [CW-1:0]     corr_nxt;
   logic [NCHUNK-1:0] mask_nxt;

   assign rsp_sig = out_q;

   // Encode/decode the current chunk and form next-state statistics.
   // NOTE: every signal gets a default before any conditional update, so
   // no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      chunk      = sig_q[k];
      calc_par   = encode(chunk);
      stored_par = par_mem[ipid_q][k];
      syn        = calc_par[H-1:0] ^ stored_par[H-1:0];
      par_err    = (^chunk) ^ (^stored_par);
      fixed      = par_err ? flip_at(chunk, syn) : chunk;
      last_chunk = (k == KW'(NCHUNK - 1));
      corr_nxt   = rsp_corr_cnt;
      mask_nxt   = rsp_uncorr_mask;
      if (par_err && rsp_corr_cnt != CW'(NCHUNK)) corr_nxt = rsp_corr_cnt + CW'(1);
      if (!par_err && syn != '0) mask_nxt[k] = 1'b1;
   end

   // Store chunk parity during enrollment.
   always_ff @(posedge clk) begin
      if (rst_n && state == S_ENROLL) par_mem[ipid_q][k] <= calc_par;
   end

   // Command FSM with registered handshake and response outputs.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cmd_ready       <= 1'b1;
         rsp_valid       <= 1'b0;
         rsp_status      <= ST_OK;
         out_q           <= '0;
         rsp_corr_cnt    <= '0;
         rsp_uncorr_mask <= '0;
         enrolled        <= '0;
         sig_q           <= '0;
         ipid_q          <= '0;
         k               <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready && cmd_op != OP_NOP) begin
                  sig_q           <= cmd_sig;
                  ipid_q          <= cmd_ipid;
                  k               <= '0;
                  out_q           <= '0;
                  rsp_corr_cnt    <= '0;
                  rsp_uncorr_mask <= '0;
                  rsp_status      <= ST_OK;
                  cmd_ready       <= 1'b0;
                  state           <= S_RESP;
                  rsp_valid       <= 1'b1;
                  if (int'(cmd_ipid) >= IPID_N) begin
                     rsp_status <= ST_BAD_IPID;
                  end else begin
                     case (cmd_op)
                        OP_CLEAR: enrolled[cmd_ipid] <= 1'b0;
                        OP_ENROLL: begin
                           if (enrolled[cmd_ipid]) begin
                              rsp_status <= ST_LOCKED;
                           end else begin
                              state     <= S_ENROLL;
                              rsp_valid <= 1'b0;
                           end
                        end
                        OP_CORRECT: begin
                           if (!enrolled[cmd_ipid]) begin
                              rsp_status <= ST_NOT_ENROLLED;
                           end else begin
                              state     <= S_CORRECT;
                              rsp_valid <= 1'b0;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
            S_ENROLL: begin
               k <= k + KW'(1);
               if (last_chunk) begin
                  enrolled[ipid_q] <= 1'b1;
                  rsp_valid        <= 1'b1;
                  state            <= S_RESP;
               end
            end
            S_CORRECT: begin
               k               <= k + KW'(1);
               out_q[k]        <= fixed;
               rsp_corr_cnt    <= corr_nxt;
               rsp_uncorr_mask <= mask_nxt;
               if (last_chunk) begin
                  if (mask_nxt != '0)      rsp_status <= ST_UNCORR;
                  else if (corr_nxt != '0) rsp_status <= ST_CORRECTED;
                  else                     rsp_status <= ST_OK;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
